cache_wb_ctl: RTL and testbench
===============================

// Module: cache_wb_ctl
// PURPOSE
//  Parametrised write-back, write-allocate, set-associative cache with a
//  miss FSM (evict, fill, replay), a per-set round-robin victim pointer and
//  a valid-clear sweep. It sits between PE/TB and main memory. It generalises
//  the fixed 1MB/4-way/32B cache, which has no miss handling.
// PARAMETERS
//  WAYS        4    ways per set; power of 2, 1..8
//  IDX_BITS    13   set index bits; 2^IDX_BITS sets
//  LINE_WORDS  8    32b words per line; power of 2, >=2
//  derived: OFF_BITS=log2(LINE_WORDS); TAG_BITS=30-IDX_BITS-OFF_BITS;
//           LINE_BITS=32*LINE_WORDS
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-high
//  a          in   32         byte address; word offset a[OFF_BITS+1:2]
//  be         in   4          byte enables for write
//  read       in   1          read request, sampled when ready=1
//  write      in   1          write request, sampled when ready=1
//  wd         in   32         write data
//  inv_all    in   1          invalidate all lines, sampled when ready=1
//  ready      out  1          FSM in IDLE; can accept a request
//  rd         out  32         read data
//  rd_valid   out  1          rd valid, one-cycle pulse
//  req_hit    out  1          lookup hit, one-cycle pulse
//  mm_a       out  32         line address; low OFF_BITS+2 bits are zero
//  mm_wd      out  LINE_BITS  eviction data
//  mm_write   out  1          eviction write, one-cycle pulse
//  mm_read    out  1          fill request, level
//  mm_rd      in   LINE_BITS  fill data
//  mm_valid   in   1          fill data valid; ignored unless state is FILL
// BEHAVIOUR
//  - Reset values: ready, rd_valid, req_hit, mm_read and mm_write are 0;
//    rd, mm_a and mm_wd are 0. State goes to INIT. Per-set victim
//    pointers go to 0.
//  - Reset mid-operation: the pending request is dropped and no response is
//    given. mm_read/mm_write are 0 from the next edge. A late mm_valid is
//    ignored.
//  - States: INIT, IDLE, LOOKUP, EVICT, FILL, INVAL.
//  - INIT/INVAL: set counter runs 0..2^IDX_BITS-1 and clears all valid and
//    dirty bits of one set per cycle; ready=0. On wrap the FSM goes to IDLE.
//    INIT therefore lasts 2^IDX_BITS cycles.
//  - IDLE: ready=1. Priority on the accepting edge: inv_all > write > read.
//    read&write together is treated as a write. Accepting registers
//    a/be/wd/op and moves to LOOKUP.
//  - LOOKUP: hit = valid & tag match on any way; at most one way may match.
//    - Hit read: rd = the selected word; rd_valid=req_hit=1 in this cycle.
//      Load-to-use latency is 1 cycle after acceptance.
//    - Hit write: bytes with be=1 are merged into the word; dirty is set.
//      req_hit=1, rd_valid=0.
//    - Every hit returns to IDLE. A hit takes 2 cycles from accept to the
//      next ready.
//    - Miss: victim = lowest-numbered invalid way, else ptr[index].
//      If the victim is valid and dirty -> EVICT, else -> FILL.
//  - EVICT (1 cycle): mm_write=1, mm_a={victim tag,index,0},
//    mm_wd=victim line; then -> FILL.
//  - FILL: mm_read=1 and mm_a={req tag,index,0} are held until mm_valid.
//    On mm_valid: line<=mm_rd, tag written, valid=1, dirty=0;
//    ptr[index]<=ptr+1 (mod WAYS) only if no invalid way existed;
//    -> LOOKUP (replay).
//  - The replay always hits. A write miss therefore merges its data on the
//    replay, which is write-allocate.
//  - req_hit/rd_valid never assert in the miss LOOKUP. Arrays use
//    registered storage with 1-cycle read; writes take effect on the edge.
// TESTING (WAYS=2, IDX_BITS=2, LINE_WORDS=4, mm model 3-cycle fill latency)
//  1. Reset release -> ready=0 for exactly 4 cycles, then 1; all outputs 0
//     during reset.
//  2. Read 0x00000010, memory word=0xCAFEF00D -> mm_read 1, mm_a=0x10, no
//     mm_write. After fill: rd=0xCAFEF00D, rd_valid=1. Re-read -> hit in
//     the 2nd cycle, no mm_read.
//  3. Write 0x14 wd=0x11223344 be=4'b0011 over 0xAAAAAAAA -> req_hit=1.
//     Read 0x14 -> rd=0xAAAA3344.
//  4. Make set 1 dirty in both ways, then read a third tag mapping to set 1
//     -> mm_write pulse, mm_a=way0 line address; fill; ptr advances; the
//     next conflict evicts way1.
//  5. Reset asserted in FILL -> mm_read=0 next cycle; mm_valid afterwards
//     has no effect; INIT then reruns.
//  6. inv_all with dirty lines -> ready=0 for 4 cycles, no mm_write;
//     the following read of the same address misses.

Source files
------------

// File: rtl/cache_wb_ctl.sv
// Write-back, write-allocate, set-associative cache controller with a miss FSM
// (evict, fill, replay), per-set round-robin victim pointers and a valid-clear sweep.
module cache_wb_ctl #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned IDX_BITS   = 13,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               a,
    input  logic [3:0]                be,
    input  logic                      read,
    input  logic                      write,
    input  logic [31:0]               wd,
    input  logic                      inv_all,
    output logic                      ready,
    output logic [31:0]               rd,
    output logic                      rd_valid,
    output logic                      req_hit,
    output logic [31:0]               mm_a,
    output logic [32*LINE_WORDS-1:0]  mm_wd,
    output logic                      mm_write,
    output logic                      mm_read,
    input  logic [32*LINE_WORDS-1:0]  mm_rd,
    input  logic                      mm_valid
);
    localparam int unsigned OFF_BITS  = $clog2(LINE_WORDS);
    localparam int unsigned TAG_BITS  = 30 - IDX_BITS - OFF_BITS;
    localparam int unsigned LINE_BITS = 32 * LINE_WORDS;
    localparam int unsigned SETS      = 1 << IDX_BITS;
    localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_INVAL} state_t;

    state_t r_state, w_next;

    logic [TAG_BITS-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_BITS-1:0] r_data  [SETS][WAYS];
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-1:0]      r_dirty [SETS];
    logic [WAY_BITS-1:0]  r_ptr   [SETS];

    logic [31:2]          r_a;
    logic [3:0]           r_be;
    logic [31:0]          r_wd;
    logic                 r_wr;
    logic [WAY_BITS-1:0]  r_vway;
    logic                 r_had_inv;
    logic [IDX_BITS-1:0]  r_cnt;

    logic [IDX_BITS-1:0]  w_idx;
    logic [TAG_BITS-1:0]  w_rtag;
    logic [OFF_BITS-1:0]  w_off;
    logic                 w_hit;
    logic [WAY_BITS-1:0]  w_hway;
    logic                 w_inv_any;
    logic [WAY_BITS-1:0]  w_fway;
    logic [WAY_BITS-1:0]  w_vway;
    logic [LINE_BITS-1:0] w_hline;
    logic [LINE_BITS-1:0] w_mline;
    logic [LINE_BITS-1:0] w_vline;
    logic [TAG_BITS-1:0]  w_vtag;
    logic [31:0]          w_word;
    logic [31:0]          w_mword;
    logic                 w_unused;

    assign w_idx    = r_a[OFF_BITS+2 +: IDX_BITS];
    assign w_rtag   = r_a[31 -: TAG_BITS];
    assign w_off    = r_a[2 +: OFF_BITS];
    assign w_unused = &{1'b0, a[1:0]};

    always_comb begin
        w_hit     = 1'b0;
        w_hway    = '0;
        w_inv_any = 1'b0;
        w_fway    = '0;
        w_mword   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][WAY_BITS'(w)] && (r_tag[w_idx][WAY_BITS'(w)] == w_rtag)) begin
                w_hit  = 1'b1;
                w_hway = WAY_BITS'(w);
            end
        end
        // Scan downwards so the lowest-numbered invalid way wins.
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!r_valid[w_idx][WAY_BITS'(WAYS-1-i)]) begin
                w_inv_any = 1'b1;
                w_fway    = WAY_BITS'(WAYS-1-i);
            end
        end
        w_vway  = w_inv_any ? w_fway : r_ptr[w_idx];
        w_hline = r_data[w_idx][w_hway];
        w_word  = w_hline[{w_off, 5'b0} +: 32];
        for (int unsigned b = 0; b < 4; b++) begin
            w_mword[8*b +: 8] = r_be[b] ? r_wd[8*b +: 8] : w_word[8*b +: 8];
        end
        w_mline = w_hline;
        w_mline[{w_off, 5'b0} +: 32] = w_mword;
        w_vline = r_data[w_idx][r_vway];
        w_vtag  = r_tag[w_idx][r_vway];
    end

    always_comb begin
        w_next   = r_state;
        ready    = 1'b0;
        rd       = '0;
        rd_valid = 1'b0;
        req_hit  = 1'b0;
        mm_a     = '0;
        mm_wd    = '0;
        mm_write = 1'b0;
        mm_read  = 1'b0;
        case (r_state)
            S_INIT, S_INVAL: begin
                if (r_cnt == '1) w_next = S_IDLE;
            end
            S_IDLE: begin
                ready = 1'b1;
                if (inv_all)              w_next = S_INVAL;
                else if (write || read)   w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    req_hit = 1'b1;
                    if (!r_wr) begin
                        rd_valid = 1'b1;
                        rd       = w_word;
                    end
                    w_next = S_IDLE;
                end else if (r_valid[w_idx][w_vway] && r_dirty[w_idx][w_vway]) begin
                    w_next = S_EVICT;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_EVICT: begin
                mm_write = 1'b1;
                mm_a     = {w_vtag, w_idx, {(OFF_BITS+2){1'b0}}};
                mm_wd    = w_vline;
                w_next   = S_FILL;
            end
            S_FILL: begin
                mm_read = 1'b1;
                mm_a    = {w_rtag, w_idx, {(OFF_BITS+2){1'b0}}};
                if (mm_valid) w_next = S_LOOKUP;
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_ptr     <= '{default: '0};
            r_a       <= '0;
            r_be      <= '0;
            r_wd      <= '0;
            r_wr      <= 1'b0;
            r_vway    <= '0;
            r_had_inv <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_INIT, S_INVAL: r_cnt <= r_cnt + 1'b1;
                S_IDLE: begin
                    if (!inv_all && (write || read)) begin
                        r_a  <= a[31:2];
                        r_be <= be;
                        r_wd <= wd;
                        r_wr <= write;
                    end
                end
                S_LOOKUP: begin
                    if (!w_hit) begin
                        r_vway    <= w_vway;
                        r_had_inv <= w_inv_any;
                    end
                end
                S_FILL: begin
                    if (mm_valid && !r_had_inv) begin
                        r_ptr[w_idx] <= (r_ptr[w_idx] == WAY_BITS'(WAYS-1)) ? '0 : r_ptr[w_idx] + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid/dirty need no reset of their own: every reset is followed by the INIT sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (r_state)
                S_INIT, S_INVAL: begin
                    r_valid[r_cnt] <= '0;
                    r_dirty[r_cnt] <= '0;
                end
                S_LOOKUP: begin
                    if (w_hit && r_wr) begin
                        r_data[w_idx][w_hway]  <= w_mline;
                        r_dirty[w_idx][w_hway] <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (mm_valid) begin
                        r_data[w_idx][r_vway]  <= mm_rd;
                        r_tag[w_idx][r_vway]   <= w_rtag;
                        r_valid[w_idx][r_vway] <= 1'b1;
                        r_dirty[w_idx][r_vway] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_wb_ctl.sv
// Scoreboard bench for cache_wb_ctl (2 ways, 4 sets, 4-word lines) with a
// 3-cycle-latency main-memory responder.
module tb_cache_wb_ctl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, read, write, inv_all, mm_valid;
    logic [31:0]  a, wd;
    logic [3:0]   be;
    logic [127:0] mm_rd;
    logic         ready, rd_valid, req_hit, mm_write, mm_read;
    logic [31:0]  rd, mm_a;
    logic [127:0] mm_wd;

    cache_wb_ctl #(.WAYS(2), .IDX_BITS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset), .a(a), .be(be), .read(read), .write(write),
        .wd(wd), .inv_all(inv_all), .ready(ready), .rd(rd), .rd_valid(rd_valid),
        .req_hit(req_hit), .mm_a(mm_a), .mm_wd(mm_wd), .mm_write(mm_write),
        .mm_read(mm_read), .mm_rd(mm_rd), .mm_valid(mm_valid)
    );

    typedef struct {bit miss; bit is_rd; logic [31:0] data;} resp_t;
    typedef struct {logic [31:0] addr; logic [127:0] line;} ev_t;

    resp_t       resp_q[$];
    logic [31:0] fill_q[$];
    ev_t         ev_q[$];
    logic [31:0] mm_mem  [256];
    logic [31:0] ref_mem [256];
    bit          saw_fill = 1'b0;
    bit          prev_rd  = 1'b0;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [127:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want none", name, act);
    endtask

    function automatic logic [127:0] ref_line(input logic [31:0] addr);
        int b;
        b = int'(addr[9:4]) * 4;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Main memory: latches mm_a when mm_read is seen, answers 3 cycles later
    // even if the request has since been withdrawn.
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        int          b;
        pend = 1'b0; cnt = 0; paddr = '0;
        mm_valid = 1'b0;
        mm_rd    = '0;
        for (int i = 0; i < 256; i++) mm_mem[i] = 32'h5000_0000 | i;
        mm_mem[4] = 32'hCAFE_F00D;
        mm_mem[5] = 32'hAAAA_AAAA;
        forever begin
            @(negedge clk);
            if (mm_write) begin
                b = int'(mm_a[9:2]);
                for (int k = 0; k < 4; k++) mm_mem[b+k] = mm_wd[32*k +: 32];
            end
            mm_valid = 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    b = int'(paddr[9:2]);
                    mm_rd    = {mm_mem[b+3], mm_mem[b+2], mm_mem[b+1], mm_mem[b]};
                    mm_valid = 1'b1;
                    pend     = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mm_read) begin
                pend  = 1'b1;
                cnt   = 3;
                paddr = mm_a;
            end
        end
    end

    initial begin
        resp_t e;
        ev_t   v;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mm_read && !prev_rd) begin
                    if (fill_q.size() == 0) flag("unexpected_fill", 128'(mm_a));
                    else chk("fill_addr", 128'(mm_a), 128'(fill_q.pop_front()));
                    saw_fill = 1'b1;
                end
                if (mm_write) begin
                    if (ev_q.size() == 0) flag("unexpected_evict", 128'(mm_a));
                    else begin
                        v = ev_q.pop_front();
                        chk("evict_addr", 128'(mm_a), 128'(v.addr));
                        chk("evict_data", mm_wd, v.line);
                    end
                end
                if (req_hit) begin
                    if (resp_q.size() == 0) flag("unexpected_hit", 128'(rd));
                    else begin
                        e = resp_q.pop_front();
                        chk("miss_seen", 128'(saw_fill), 128'(e.miss));
                        chk("rd_valid", 128'(rd_valid), 128'(e.is_rd));
                        if (e.is_rd) chk("rd_data", 128'(rd), 128'(e.data));
                    end
                    saw_fill = 1'b0;
                end else if (rd_valid) begin
                    flag("rd_valid_without_hit", 128'(rd));
                end
            end
            prev_rd = mm_read;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        flag("ready_timeout", 128'(ready));
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] bmask,
                          input logic [31:0] data, input bit miss, input logic [31:0] exp_rd);
        resp_t r;
        int    n;
        bit    ok;
        wait_ready();
        r.miss = miss; r.is_rd = !wr; r.data = exp_rd;
        resp_q.push_back(r);
        if (miss) fill_q.push_back({addr[31:4], 4'h0});
        a = addr; be = bmask; wd = data; write = wr; read = !wr;
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        n = 0; ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1 && !miss && !wr) chk("load_to_use", 128'(rd_valid), 128'd1);
            if (ready) ok = 1'b1;
        end
        if (!ok) flag("req_timeout", 128'(n));
        else if (!miss) chk("hit_turnaround", 128'(n), 128'd2);
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (!ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(name, 128'(n), 128'd4);
    endtask

    task automatic check_quiet(input string name);
        chk(name, {ready, rd_valid, req_hit, mm_read, mm_write, rd, mm_a}, '0);
        chk({name, "_mm_wd"}, mm_wd, '0);
    endtask

    initial begin
        int n;
        reset = 1'b1; read = 1'b0; write = 1'b0; inv_all = 1'b0;
        a = '0; wd = '0; be = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h5000_0000 | i;
        ref_mem[4] = 32'hCAFE_F00D;
        ref_mem[5] = 32'hAAAA_AAAA;

        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        reset = 1'b0;
        count_init("init_cycles");

        do_req(1'b0, 32'h10, 4'h0, '0, 1'b1, 32'hCAFE_F00D);
        do_req(1'b0, 32'h10, 4'h0, '0, 1'b0, 32'hCAFE_F00D);

        do_req(1'b1, 32'h14, 4'b0011, 32'h1122_3344, 1'b0, '0);
        ref_mem[5] = 32'hAAAA_3344;
        do_req(1'b0, 32'h14, 4'h0, '0, 1'b0, 32'hAAAA_3344);

        do_req(1'b1, 32'h50, 4'hF, 32'h5566_7788, 1'b1, '0);
        ref_mem[20] = 32'h5566_7788;
        ev_q.push_back('{addr: 32'h10, line: ref_line(32'h10)});
        do_req(1'b0, 32'h90, 4'h0, '0, 1'b1, 32'h5000_0024);
        ev_q.push_back('{addr: 32'h50, line: ref_line(32'h50)});
        do_req(1'b0, 32'hD4, 4'h0, '0, 1'b1, 32'h5000_0035);
        do_req(1'b0, 32'h14, 4'h0, '0, 1'b1, 32'hAAAA_3344);
        do_req(1'b0, 32'h50, 4'h0, '0, 1'b1, 32'h5566_7788);
        chk("evictions_done", 128'(ev_q.size()), 128'd0);

        do_req(1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF, 1'b1, '0);
        wait_ready();
        inv_all = 1'b1;
        @(posedge clk);
        #1;
        inv_all = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (!ready) n++;
        end while (!ready && n < 50);
        chk("inval_cycles", 128'(n), 128'd4);
        do_req(1'b0, 32'h20, 4'h0, '0, 1'b1, 32'h5000_0008);

        wait_ready();
        fill_q.push_back(32'h60);
        a = 32'h60; read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mm_read && n < 50);
        chk("fill_started", 128'(mm_read), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("reset_in_fill");
        resp_q.delete();
        fill_q.delete();
        saw_fill = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        count_init("reinit_cycles");
        do_req(1'b0, 32'h60, 4'h0, '0, 1'b1, 32'h5000_0018);

        repeat (8) @(negedge clk);
        chk("resp_q_empty", 128'(resp_q.size()), 128'd0);
        chk("fill_q_empty", 128'(fill_q.size()), 128'd0);
        chk("ev_q_empty", 128'(ev_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
